// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: tracks pending register writes and arbitrates two writeback sources onto one write port.
module regfile_wb_sched #(
  parameter int XLEN    = 64,
  parameter int REG_NUM = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_en,
  input  logic [4:0]         issue_rd,
  input  logic               rs1_en,
  input  logic               rs2_en,
  input  logic [4:0]         rs1_addr,
  input  logic [4:0]         rs2_addr,
  output logic               stall,
  input  logic               exu_wb_valid,
  input  logic [4:0]         exu_wb_addr,
  input  logic [XLEN-1:0]    exu_wb_data,
  output logic               exu_wb_ready,
  input  logic               lsu_wb_valid,
  input  logic [4:0]         lsu_wb_addr,
  input  logic [XLEN-1:0]    lsu_wb_data,
  output logic               lsu_wb_ready,
  output logic               wr_en,
  output logic [4:0]         wr_addr,
  output logic [XLEN-1:0]    wr_data,
  output logic [REG_NUM-1:0] busy_vec,
  output logic               wb_err
);
  localparam logic [REG_NUM-1:0] ONE = REG_NUM'(1);
  logic [REG_NUM-1:0] busy_q, busy_d, set_m, clr_m;
  logic               ptr_q, ptr_d, wr_en_q, wr_en_d, wb_err_q, wb_err_d;
  logic [4:0]         wr_addr_q, wr_addr_d, hs_addr;
  logic [XLEN-1:0]    wr_data_q, wr_data_d, hs_data;
  logic               exu_hs, lsu_hs, hs, acc;
  assign stall = (rs1_en & busy_q[rs1_addr]) | (rs2_en & busy_q[rs2_addr]) | (issue_en & busy_q[issue_rd]);
  // ptr_q low favours EXU when both sources request
  assign exu_wb_ready = ~rst & exu_wb_valid & (~lsu_wb_valid | ~ptr_q);
  assign lsu_wb_ready = ~rst & lsu_wb_valid & (~exu_wb_valid | ptr_q);
  always_comb begin
    exu_hs    = exu_wb_valid & exu_wb_ready;
    lsu_hs    = lsu_wb_valid & lsu_wb_ready;
    hs        = exu_hs | lsu_hs;
    hs_addr   = lsu_hs ? lsu_wb_addr : exu_wb_addr;
    hs_data   = lsu_hs ? lsu_wb_data : exu_wb_data;
    acc       = issue_en & ~stall;
    set_m     = acc ? ONE << issue_rd : '0;
    clr_m     = hs ? ONE << hs_addr : '0;
    busy_d    = ((busy_q & ~clr_m) | set_m) & ~ONE;
    ptr_d     = exu_hs ? 1'b1 : lsu_hs ? 1'b0 : ptr_q;
    wr_en_d   = hs & (hs_addr != 5'd0);
    wr_addr_d = hs ? hs_addr : 5'd0;
    wr_data_d = hs ? hs_data : '0;
    wb_err_d  = wb_err_q | (wr_en_d & ~busy_q[hs_addr]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      ptr_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 5'd0;
      wr_data_q <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wb_err_q  <= wb_err_d;
    end
  end
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy_vec = busy_q;
  assign wb_err   = wb_err_q;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched: directed scenario tests for the writeback scheduler.
module tb_regfile_wb_sched;
  logic        clk = 0;
  logic        rst, issue_en, rs1_en, rs2_en, stall;
  logic [4:0]  issue_rd, rs1_addr, rs2_addr, exu_wb_addr, lsu_wb_addr, wr_addr;
  logic        exu_wb_valid, exu_wb_ready, lsu_wb_valid, lsu_wb_ready, wr_en, wb_err;
  logic [63:0] exu_wb_data, lsu_wb_data, wr_data;
  logic [31:0] busy_vec;
  int tests = 0;
  int fails = 0;

  regfile_wb_sched dut (
    .clk(clk), .rst(rst), .issue_en(issue_en), .issue_rd(issue_rd),
    .rs1_en(rs1_en), .rs2_en(rs2_en), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .stall(stall),
    .exu_wb_valid(exu_wb_valid), .exu_wb_addr(exu_wb_addr), .exu_wb_data(exu_wb_data), .exu_wb_ready(exu_wb_ready),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_addr(lsu_wb_addr), .lsu_wb_data(lsu_wb_data), .lsu_wb_ready(lsu_wb_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy_vec(busy_vec), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    issue_en = 0; issue_rd = 0; rs1_en = 0; rs2_en = 0; rs1_addr = 0; rs2_addr = 0;
    exu_wb_valid = 0; exu_wb_addr = 0; exu_wb_data = 0;
    lsu_wb_valid = 0; lsu_wb_addr = 0; lsu_wb_data = 0;
  endtask

  task automatic do_reset;
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_en = 1; issue_rd = rd;
    tick();
    issue_en = 0; issue_rd = 0;
  endtask

  task automatic test_reset;
    idle();
    rst = 1;
    exu_wb_valid = 1; exu_wb_addr = 5'd1; lsu_wb_valid = 1; lsu_wb_addr = 5'd2;
    #1;
    tests++; if (exu_wb_ready !== 1'b0 || lsu_wb_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got exu=%b lsu=%b exp 0 0", exu_wb_ready, lsu_wb_ready); end
    tick();
    idle();
    rst = 0;
    tests++; if (busy_vec !== 32'h0) begin fails++; $display("FAIL reset_busy got %h exp 0", busy_vec); end
    tests++; if ({wr_en, wr_addr, wr_data, wb_err} !== '0) begin fails++; $display("FAIL reset_wr got en=%b addr=%0d data=%h err=%b exp all 0", wr_en, wr_addr, wr_data, wb_err); end
  endtask

  task automatic test_raw_hazard;
    do_reset();
    issue_en = 1; issue_rd = 5'd5;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL raw_issue_stall got %b exp 0", stall); end
    tick();
    issue_en = 0; rs1_en = 1; rs1_addr = 5'd5;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL raw_stall got %b exp 1", stall); end
    tests++; if (busy_vec !== 32'h20) begin fails++; $display("FAIL raw_busy got %h exp 00000020", busy_vec); end
    exu_wb_valid = 1; exu_wb_addr = 5'd5; exu_wb_data = 64'hDEAD_BEEF_0000_0005;
    #1;
    tests++; if (exu_wb_ready !== 1'b1) begin fails++; $display("FAIL raw_exu_ready got %b exp 1", exu_wb_ready); end
    tick();
    exu_wb_valid = 0;
    #1;
    tests++; if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 64'hDEAD_BEEF_0000_0005) begin fails++; $display("FAIL raw_write got en=%b addr=%0d data=%h exp 1 5 deadbeef00000005", wr_en, wr_addr, wr_data); end
    tests++; if (busy_vec !== 32'h0 || stall !== 1'b0) begin fails++; $display("FAIL raw_clear got busy=%h stall=%b exp 0 0", busy_vec, stall); end
    tests++; if (wb_err !== 1'b0) begin fails++; $display("FAIL raw_err got %b exp 0", wb_err); end
    idle();
    tick();
    tests++; if ({wr_en, wr_addr, wr_data} !== '0) begin fails++; $display("FAIL raw_idle got en=%b addr=%0d data=%h exp 0", wr_en, wr_addr, wr_data); end
  endtask

  task automatic test_arbitration;
    do_reset();
    issue(5'd3);
    issue(5'd4);
    exu_wb_valid = 1; exu_wb_addr = 5'd3; exu_wb_data = 64'hA3;
    lsu_wb_valid = 1; lsu_wb_addr = 5'd4; lsu_wb_data = 64'hB4;
    #1;
    tests++; if (exu_wb_ready !== 1'b1 || lsu_wb_ready !== 1'b0) begin fails++; $display("FAIL arb_first got exu=%b lsu=%b exp 1 0", exu_wb_ready, lsu_wb_ready); end
    tick();
    exu_wb_valid = 0;
    #1;
    tests++; if (wr_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 64'hA3) begin fails++; $display("FAIL arb_wr3 got en=%b addr=%0d data=%h exp 1 3 a3", wr_en, wr_addr, wr_data); end
    tests++; if (lsu_wb_ready !== 1'b1) begin fails++; $display("FAIL arb_second got %b exp 1", lsu_wb_ready); end
    tick();
    lsu_wb_valid = 0;
    #1;
    tests++; if (wr_en !== 1'b1 || wr_addr !== 5'd4 || wr_data !== 64'hB4) begin fails++; $display("FAIL arb_wr4 got en=%b addr=%0d data=%h exp 1 4 b4", wr_en, wr_addr, wr_data); end
    tests++; if (busy_vec !== 32'h0 || wb_err !== 1'b0) begin fails++; $display("FAIL arb_clear got busy=%h err=%b exp 0 0", busy_vec, wb_err); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    issue(5'd10);
    issue(5'd11);
    issue(5'd12);
    exu_wb_valid = 1; exu_wb_addr = 5'd10; exu_wb_data = 64'h10;
    lsu_wb_valid = 1; lsu_wb_addr = 5'd11; lsu_wb_data = 64'h11;
    tick();
    exu_wb_addr = 5'd12; exu_wb_data = 64'h12;
    #1;
    tests++; if (exu_wb_ready !== 1'b0 || lsu_wb_ready !== 1'b1) begin fails++; $display("FAIL b2b_ptr got exu=%b lsu=%b exp 0 1", exu_wb_ready, lsu_wb_ready); end
    tests++; if (wr_addr !== 5'd10) begin fails++; $display("FAIL b2b_wr10 got %0d exp 10", wr_addr); end
    tick();
    lsu_wb_valid = 0;
    #1;
    tests++; if (wr_addr !== 5'd11 || exu_wb_ready !== 1'b1) begin fails++; $display("FAIL b2b_wr11 got addr=%0d exu_ready=%b exp 11 1", wr_addr, exu_wb_ready); end
    tick();
    exu_wb_valid = 0;
    #1;
    tests++; if (wr_addr !== 5'd12 || wr_data !== 64'h12 || busy_vec !== 32'h0) begin fails++; $display("FAIL b2b_wr12 got addr=%0d data=%h busy=%h exp 12 12 0", wr_addr, wr_data, busy_vec); end
  endtask

  task automatic test_same_reg;
    do_reset();
    issue(5'd7);
    issue_en = 1; issue_rd = 5'd7;
    exu_wb_valid = 1; exu_wb_addr = 5'd7; exu_wb_data = 64'h77;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL same_stall got %b exp 1", stall); end
    tick();
    exu_wb_valid = 0;
    #1;
    tests++; if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wb_err !== 1'b0) begin fails++; $display("FAIL same_write got en=%b addr=%0d err=%b exp 1 7 0", wr_en, wr_addr, wb_err); end
    tick();
    issue_en = 0;
    tests++; if (busy_vec[7] !== 1'b1) begin fails++; $display("FAIL same_busy7 got %b exp 1", busy_vec[7]); end
  endtask

  task automatic test_wb_err;
    do_reset();
    lsu_wb_valid = 1; lsu_wb_addr = 5'd9; lsu_wb_data = 64'h99;
    #1;
    tests++; if (lsu_wb_ready !== 1'b1) begin fails++; $display("FAIL err_ready got %b exp 1", lsu_wb_ready); end
    tick();
    lsu_wb_valid = 0;
    #1;
    tests++; if (wr_en !== 1'b1 || wr_addr !== 5'd9 || wb_err !== 1'b1) begin fails++; $display("FAIL err_set got en=%b addr=%0d err=%b exp 1 9 1", wr_en, wr_addr, wb_err); end
    tick();
    tick();
    tests++; if (wb_err !== 1'b1 || wr_en !== 1'b0) begin fails++; $display("FAIL err_hold got err=%b en=%b exp 1 0", wb_err, wr_en); end
  endtask

  task automatic test_x0;
    do_reset();
    issue_en = 1; issue_rd = 5'd0;
    exu_wb_valid = 1; exu_wb_addr = 5'd0; exu_wb_data = 64'h55;
    tick();
    idle();
    tests++; if (busy_vec !== 32'h0 || wr_en !== 1'b0 || wb_err !== 1'b0) begin fails++; $display("FAIL x0 got busy=%h en=%b err=%b exp 0 0 0", busy_vec, wr_en, wb_err); end
  endtask

  task automatic test_reset_priority;
    do_reset();
    issue(5'd4);
    issue(5'd5);
    issue(5'd6);
    issue(5'd7);
    tests++; if (busy_vec !== 32'hF0) begin fails++; $display("FAIL rstp_busy got %h exp 000000f0", busy_vec); end
    rst = 1;
    issue_en = 1; issue_rd = 5'd8;
    exu_wb_valid = 1; exu_wb_addr = 5'd4; exu_wb_data = 64'h4;
    lsu_wb_valid = 1; lsu_wb_addr = 5'd5; lsu_wb_data = 64'h5;
    #1;
    tests++; if (exu_wb_ready !== 1'b0 || lsu_wb_ready !== 1'b0) begin fails++; $display("FAIL rstp_ready got exu=%b lsu=%b exp 0 0", exu_wb_ready, lsu_wb_ready); end
    tick();
    tests++; if (busy_vec !== 32'h0 || wr_en !== 1'b0 || wr_addr !== 5'd0) begin fails++; $display("FAIL rstp_clear got busy=%h en=%b addr=%0d exp 0 0 0", busy_vec, wr_en, wr_addr); end
    tests++; if (exu_wb_ready !== 1'b0 || lsu_wb_ready !== 1'b0) begin fails++; $display("FAIL rstp_ready2 got exu=%b lsu=%b exp 0 0", exu_wb_ready, lsu_wb_ready); end
    rst = 0;
    idle();
    tick();
  endtask

  initial begin
    rst = 1;
    idle();
    tick();
    test_reset();
    test_raw_hazard();
    test_arbitration();
    test_back_to_back();
    test_same_reg();
    test_wb_err();
    test_x0();
    test_reset_priority();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
